// File: rtl/mem_arbiter_pkg.sv
// Shared types and default limits for the instruction/data RAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } arb_state_t;

  localparam int ARB_STARVE_MAX = 4;
  localparam int ARB_TIMEOUT    = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side bus bundle of the memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  import mem_arbiter_pkg::*;

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [ADDR_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              dhit;
  logic [ADDR_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              bus_err;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

  modport cache (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, iload, dhit, dload, bus_err
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

endinterface

// File: rtl/mem_arbiter_counter.sv
// Saturating up-counter with synchronous clear and a reached-limit flag.
module mem_arbiter_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data wins ties unless instruction fetch is starved;
// aborts an access on RAM ERROR or when the RAM stays silent too long.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX,
  parameter int TIMEOUT    = ARB_TIMEOUT,
  parameter int ADDR_W     = 32
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.arb    bus
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] store_q, store_d;
  logic              wen_q, wen_d;

  logic starve_max, tmo_max;
  logic grant_d, grant_i;
  logic in_acc, complete, waiting, fault;

  assign in_acc   = (state_q != IDLE);
  assign complete = in_acc && (bus.ramstate == ACCESS);
  // FREE/BUSY both count as "still waiting" for the RAM
  assign waiting  = in_acc && (bus.ramstate == FREE || bus.ramstate == BUSY);
  assign fault    = in_acc && ((bus.ramstate == ERROR) || (waiting && tmo_max));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wen_d   = wen_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state_q)
      IDLE: begin
        if ((bus.dREN || bus.dWEN) && !(bus.iREN && starve_max)) begin
          grant_d = 1'b1;
          state_d = D_ACC;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          wen_d   = bus.dWEN;
        end else if (bus.iREN) begin
          grant_i = 1'b1;
          state_d = I_ACC;
          addr_d  = bus.iaddr;
          store_d = '0;
          wen_d   = 1'b0;
        end
      end
      I_ACC, D_ACC: begin
        if (complete || fault)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wen_q   <= wen_d;
    end
  end

  mem_arbiter_counter #(.MAX(STARVE_MAX), .W($clog2(STARVE_MAX) + 1)) u_starve (
    .clk    (CLK),
    .rst    (RST),
    .clr    (grant_i),
    .inc    (grant_d && bus.iREN),
    .at_max (starve_max)
  );

  // Limit is TIMEOUT-1 because the entry cycle itself is counted as cycle 0
  mem_arbiter_counter #(.MAX(TIMEOUT - 1), .W($clog2(TIMEOUT) + 1)) u_tmo (
    .clk    (CLK),
    .rst    (RST),
    .clr    (grant_d || grant_i),
    .inc    (waiting),
    .at_max (tmo_max)
  );

  // RAM side is driven from latched registers only, and only in access states
  assign bus.ramREN   = (state_q == I_ACC) || (state_q == D_ACC && !wen_q);
  assign bus.ramWEN   = (state_q == D_ACC) && wen_q;
  assign bus.ramaddr  = in_acc ? addr_q : '0;
  assign bus.ramstore = in_acc ? store_q : '0;

  assign bus.ihit    = (state_q == I_ACC) && complete;
  assign bus.dhit    = (state_q == D_ACC) && complete;
  assign bus.iload   = bus.ihit ? bus.ramload : '0;
  assign bus.dload   = bus.dhit ? bus.ramload : '0;
  assign bus.bus_err = fault;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter with a queue of expected completions.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic CLK, RST;
  mem_arbiter_if #(.ADDR_W(32)) bus();

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(16), .ADDR_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] addr;
    logic [31:0] load;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    @(posedge CLK); @(negedge CLK);
    n_vec++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b required 00", {bus.ramREN, bus.ramWEN}); end
    n_vec++; if ({bus.ihit, bus.dhit, bus.bus_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b required 000", {bus.ihit, bus.dhit, bus.bus_err}); end
    n_vec++; if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin n_err++; $display("FAIL reset_bus: got %h/%h required 0/0", bus.ramaddr, bus.ramstore); end
    n_vec++; if (bus.iload !== 32'h0 || bus.dload !== 32'h0) begin n_err++; $display("FAIL reset_loads: got %h/%h required 0/0", bus.iload, bus.dload); end
    @(posedge CLK); #1; RST = 1'b0;
  endtask

  task automatic test_ifetch_zero_wait();
    exp_t e;
    @(posedge CLK); #1;
    bus.iREN = 1; bus.iaddr = 32'h0000_0040; bus.ramstate = ACCESS; bus.ramload = 32'h2008_0001;
    sb.push_back('{0, 0, 32'h0000_0040, 32'h2008_0001});
    @(negedge CLK);
    n_vec++; if ({bus.ramREN, bus.ramWEN, bus.ihit} !== 3'b000) begin n_err++; $display("FAIL if_req_cycle: got %b required 000", {bus.ramREN, bus.ramWEN, bus.ihit}); end
    @(negedge CLK);
    n_vec++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin n_err++; $display("FAIL if_ram_drive: got ren=%b addr=%h required ren=1 addr=00000040", bus.ramREN, bus.ramaddr); end
    if (bus.ihit || bus.dhit) begin
      e = sb.pop_front();
      n_vec++; if ({bus.dhit, bus.ihit} !== {e.is_d, !e.is_d}) begin n_err++; $display("FAIL if_hit_kind: got d/i=%b%b required %b%b", bus.dhit, bus.ihit, e.is_d, !e.is_d); end
      n_vec++; if (bus.iload !== e.load) begin n_err++; $display("FAIL if_load: got %h required %h", bus.iload, e.load); end
    end else begin
      n_vec++; n_err++; $display("FAIL if_hit: got ihit=0 required ihit=1");
      sb.delete();
    end
    @(posedge CLK); #1; bus.iREN = 0;
    @(negedge CLK);
    n_vec++; if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.iload != 0} !== 4'b0000) begin n_err++; $display("FAIL if_bubble: got %b required 0000", {bus.ramREN, bus.ramWEN, bus.ihit, bus.iload != 0}); end
  endtask

  task automatic test_tie_data_first();
    exp_t e;
    int   hits = 0;
    @(posedge CLK); #1;
    bus.iREN = 1; bus.iaddr = 32'h80; bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
    bus.ramstate = ACCESS; bus.ramload = 32'h0000_1234;
    sb.push_back('{1, 0, 32'h100, 32'h0000_1234});
    sb.push_back('{0, 0, 32'h80, 32'h0000_1234});
    @(negedge CLK);
    @(negedge CLK);
    n_vec++; if ({bus.ramWEN, bus.ramREN} !== 2'b10 || bus.ramstore !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL tie_write: got wen/ren=%b%b store=%h required 10 deadbeef", bus.ramWEN, bus.ramREN, bus.ramstore); end
    for (int c = 0; c < 8 && hits < 2; c++) begin
      if (bus.ihit || bus.dhit) begin
        e = sb.pop_front(); hits++;
        n_vec++; if ({bus.dhit, bus.ihit} !== {e.is_d, !e.is_d}) begin n_err++; $display("FAIL tie_order: got d/i=%b%b required %b%b", bus.dhit, bus.ihit, e.is_d, !e.is_d); end
        n_vec++; if (bus.ramaddr !== e.addr) begin n_err++; $display("FAIL tie_addr: got %h required %h", bus.ramaddr, e.addr); end
        @(posedge CLK); #1;
        if (e.is_d) bus.dWEN = 0; else bus.iREN = 0;
      end else begin
        @(posedge CLK); #1;
      end
      @(negedge CLK);
    end
    n_vec++; if (hits !== 2) begin n_err++; $display("FAIL tie_hits: got %0d required 2", hits); sb.delete(); end
  endtask

  task automatic test_starvation();
    exp_t e;
    int   hits = 0;
    @(posedge CLK); #1;
    bus.iREN = 1; bus.iaddr = 32'h300; bus.dREN = 1; bus.daddr = 32'h200;
    bus.ramstate = ACCESS; bus.ramload = 32'h0000_CAFE;
    for (int k = 0; k < 10; k++)
      sb.push_back('{(k != 4 && k != 9), 0, ((k == 4 || k == 9) ? 32'h300 : 32'h200), 32'h0000_CAFE});
    for (int c = 0; c < 40 && hits < 10; c++) begin
      @(negedge CLK);
      if (bus.ihit || bus.dhit) begin
        e = sb.pop_front(); hits++;
        n_vec++; if ({bus.dhit, bus.ihit} !== {e.is_d, !e.is_d}) begin n_err++; $display("FAIL starve_grant%0d: got d/i=%b%b required %b%b", hits, bus.dhit, bus.ihit, e.is_d, !e.is_d); end
        n_vec++; if (bus.ramaddr !== e.addr) begin n_err++; $display("FAIL starve_addr%0d: got %h required %h", hits, bus.ramaddr, e.addr); end
        n_vec++; if ((e.is_d ? bus.dload : bus.iload) !== e.load) begin n_err++; $display("FAIL starve_load%0d: got %h required %h", hits, (e.is_d ? bus.dload : bus.iload), e.load); end
        if (hits == 10) begin @(posedge CLK); #1; bus.iREN = 0; bus.dREN = 0; end
      end
    end
    n_vec++; if (hits !== 10) begin n_err++; $display("FAIL starve_hits: got %0d required 10", hits); sb.delete(); bus.iREN = 0; bus.dREN = 0; end
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   acc = 0;
    bit   seen = 0;
    @(posedge CLK); #1;
    bus.dREN = 1; bus.daddr = 32'h400; bus.ramstate = BUSY;
    sb.push_back('{1, 1, 32'h400, 32'h0});
    @(negedge CLK);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge CLK);
      if (bus.ramREN) acc++;
      if (bus.dhit) begin n_vec++; n_err++; $display("FAIL tmo_nohit: got dhit=1 required 0"); end
      if (bus.bus_err) begin
        seen = 1; e = sb.pop_front();
        n_vec++; if (e.err !== 1'b1) begin n_err++; $display("FAIL tmo_kind: got bus_err required hit"); end
      end
    end
    n_vec++; if (!seen || acc !== 16) begin n_err++; $display("FAIL tmo_cycles: got %0d access cycles (err=%b) required 16", acc, seen); end
    @(negedge CLK);
    n_vec++; if ({bus.ramREN, bus.bus_err, bus.dhit} !== 3'b000) begin n_err++; $display("FAIL tmo_bubble: got %b required 000", {bus.ramREN, bus.bus_err, bus.dhit}); end
    @(negedge CLK);
    n_vec++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h400) begin n_err++; $display("FAIL tmo_regrant: got ren=%b addr=%h required 1 00000400", bus.ramREN, bus.ramaddr); end
    @(posedge CLK); #1; bus.ramstate = ACCESS; bus.ramload = 32'h0000_0077;
    sb.push_back('{1, 0, 32'h400, 32'h0000_0077});
    @(negedge CLK);
    if (bus.dhit) begin
      e = sb.pop_front();
      n_vec++; if (bus.dload !== e.load) begin n_err++; $display("FAIL tmo_retry_load: got %h required %h", bus.dload, e.load); end
    end else begin
      n_vec++; n_err++; $display("FAIL tmo_retry_hit: got dhit=0 required 1"); sb.delete();
    end
    @(posedge CLK); #1; bus.dREN = 0;
    @(negedge CLK);
  endtask

  task automatic test_error_ifetch();
    exp_t e;
    @(posedge CLK); #1;
    bus.iREN = 1; bus.iaddr = 32'h500; bus.ramstate = ERROR;
    sb.push_back('{0, 1, 32'h500, 32'h0});
    sb.push_back('{0, 0, 32'h500, 32'h0000_0099});
    @(negedge CLK);
    @(negedge CLK);
    n_vec++; if ({bus.ramREN, bus.bus_err, bus.ihit} !== 3'b110) begin n_err++; $display("FAIL err_pulse: got ren/err/ihit=%b required 110", {bus.ramREN, bus.bus_err, bus.ihit}); end
    if (bus.bus_err) e = sb.pop_front();
    @(posedge CLK); #1; bus.ramstate = ACCESS; bus.ramload = 32'h0000_0099;
    @(negedge CLK);
    n_vec++; if ({bus.ramREN, bus.bus_err} !== 2'b00) begin n_err++; $display("FAIL err_one_cycle: got ren/err=%b required 00", {bus.ramREN, bus.bus_err}); end
    @(negedge CLK);
    if (bus.ihit && sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++; if (bus.iload !== e.load || e.err) begin n_err++; $display("FAIL err_retry_load: got %h required %h", bus.iload, e.load); end
    end else begin
      n_vec++; n_err++; $display("FAIL err_retry_hit: got ihit=%b required 1", bus.ihit); sb.delete();
    end
    @(posedge CLK); #1; bus.iREN = 0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_access();
    @(posedge CLK); #1;
    bus.dWEN = 1; bus.daddr = 32'h600; bus.dstore = 32'h55; bus.ramstate = BUSY;
    @(negedge CLK);
    @(negedge CLK);
    n_vec++; if (bus.ramWEN !== 1'b1 || bus.ramstore !== 32'h55) begin n_err++; $display("FAIL rst_pre: got wen=%b store=%h required 1 00000055", bus.ramWEN, bus.ramstore); end
    #2 RST = 1'b1;
    #1;
    n_vec++; if ({bus.ramREN, bus.ramWEN, bus.dhit, bus.bus_err} !== 4'b0000 || bus.ramaddr !== 32'h0) begin n_err++; $display("FAIL rst_async: got %b addr=%h required 0000 00000000", {bus.ramREN, bus.ramWEN, bus.dhit, bus.bus_err}, bus.ramaddr); end
    @(posedge CLK); #1; bus.dWEN = 0;
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    n_vec++; if ({bus.ramREN, bus.ramWEN, bus.bus_err} !== 3'b000) begin n_err++; $display("FAIL rst_release: got %b required 000", {bus.ramREN, bus.ramWEN, bus.bus_err}); end
    @(posedge CLK); #1;
    bus.iREN = 1; bus.iaddr = 32'h700; bus.ramstate = ACCESS; bus.ramload = 32'h0000_0A0A;
    @(negedge CLK);
    @(negedge CLK);
    n_vec++; if (bus.ihit !== 1'b1 || bus.iload !== 32'h0000_0A0A) begin n_err++; $display("FAIL rst_after_fetch: got ihit=%b iload=%h required 1 00000a0a", bus.ihit, bus.iload); end
    @(posedge CLK); #1; bus.iREN = 0;
  endtask

  initial begin
    test_reset();
    test_ifetch_zero_wait();
    test_tie_data_first();
    test_starvation();
    test_timeout();
    test_error_ifetch();
    test_reset_mid_access();
    n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL sb_drain: got %0d pending required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
